// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with per-producer holding buffers
// Each producer owns a one-entry buffer; buffered results are broadcast one per cycle.
module cdb_arbiter #(
  parameter int N_REQ  = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int SRC_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src,
  output logic                    err_overflow
);

  logic [N_REQ-1:0]  buf_v_q;
  logic [TAG_W-1:0]  buf_tag_q  [N_REQ];
  logic [DATA_W-1:0] buf_data_q [N_REQ];
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;
  logic              err_overflow_q;

  logic              found;
  logic [SRC_W-1:0]  win;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  drop;

  // Two passes: entries at or above rr_ptr first, then the wrapped-around low entries.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && buf_v_q[i] && (SRC_W'(i) >= rr_ptr_q)) begin
        found    = 1'b1;
        win      = SRC_W'(i);
        win_tag  = buf_tag_q[i];
        win_data = buf_data_q[i];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && buf_v_q[i]) begin
        found    = 1'b1;
        win      = SRC_W'(i);
        win_tag  = buf_tag_q[i];
        win_data = buf_data_q[i];
      end
    end
    if (flush) begin
      found = 1'b0;
    end
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = found && (win == SRC_W'(i));
    end
  end

  assign rr_ptr_d  = (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign req_ready = ~buf_v_q | grant;
  assign accept    = req_valid & req_ready;
  assign drop      = req_valid & ~req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q        <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        buf_tag_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= '0;
      err_overflow_q <= 1'b0;
    end else if (flush) begin
      // Squash everything in flight; incoming strobes are discarded, not counted as drops.
      buf_v_q     <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          buf_v_q[i]    <= 1'b1;
          buf_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
          buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_v_q[i] <= 1'b0;
        end
      end
      if (|drop) begin
        err_overflow_q <= 1'b1;
      end
      cdb_valid_q <= found;
      if (found) begin
        cdb_tag_q  <= win_tag;
        cdb_data_q <= win_data;
        cdb_src_q  <= win;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed-vector bench for cdb_arbiter
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [5:0]  req_valid;
  logic [23:0] req_tag;
  logic [191:0] req_data;
  logic [5:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [2:0]  cdb_src;
  logic        err_overflow;

  int nvec;
  int nerr;

  cdb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] t, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_tag[i*4 +: 4]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (req_ready !== 6'b111111) begin nerr++; $display("FAIL reset_ready: got %b expected 111111", req_ready); end
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", cdb_valid); end
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
    nvec++; if ({cdb_tag, cdb_data, cdb_src} !== 39'd0) begin nerr++; $display("FAIL reset_bus: got %h expected 0", {cdb_tag, cdb_data, cdb_src}); end
  endtask

  task automatic test_single();
    set_req(3, 4'h5, 32'hDEAD_BEEF);
    tick();
    req_valid = '0;
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL single_early: got %b expected 0", cdb_valid); end
    tick();
    nvec++; if (cdb_valid !== 1'b1) begin nerr++; $display("FAIL single_valid: got %b expected 1", cdb_valid); end
    nvec++; if (cdb_tag !== 4'h5) begin nerr++; $display("FAIL single_tag: got %h expected 5", cdb_tag); end
    nvec++; if (cdb_data !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL single_data: got %h expected deadbeef", cdb_data); end
    nvec++; if (cdb_src !== 3'd3) begin nerr++; $display("FAIL single_src: got %0d expected 3", cdb_src); end
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL single_once: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_all_six();
    do_reset();
    for (int i = 0; i < 6; i++) set_req(i, 4'(i + 1), 32'hA000_0000 + i);
    tick();
    req_valid = '0;
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL all6_early: got %b expected 0", cdb_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'(i)) begin nerr++; $display("FAIL all6_seq%0d: got v=%b src=%0d expected v=1 src=%0d", i, cdb_valid, cdb_src, i); end
      nvec++; if (cdb_tag !== 4'(i + 1) || cdb_data !== 32'hA000_0000 + i) begin nerr++; $display("FAIL all6_payload%0d: got %h/%h expected %h/%h", i, cdb_tag, cdb_data, 4'(i + 1), 32'hA000_0000 + i); end
    end
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL all6_end: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_wrap_fair();
    // rr_ptr is 0 here; granting requester 4 moves it to 5.
    set_req(4, 4'h3, 32'h4444_4444);
    tick();
    req_valid = '0;
    tick();
    nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd4) begin nerr++; $display("FAIL wrap_setup: got v=%b src=%0d expected v=1 src=4", cdb_valid, cdb_src); end
    set_req(5, 4'hA, 32'h5A5A_5A5A);
    set_req(0, 4'hB, 32'h0B0B_0B0B);
    tick();
    req_valid = '0;
    tick();
    nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd5 || cdb_tag !== 4'hA) begin nerr++; $display("FAIL wrap_first: got v=%b src=%0d tag=%h expected v=1 src=5 tag=a", cdb_valid, cdb_src, cdb_tag); end
    tick();
    nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd0 || cdb_data !== 32'h0B0B_0B0B) begin nerr++; $display("FAIL wrap_second: got v=%b src=%0d data=%h expected v=1 src=0 data=0b0b0b0b", cdb_valid, cdb_src, cdb_data); end
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL wrap_end: got %b expected 0", cdb_valid); end
    // rr_ptr is now 1: producers 0 and 1 refill whenever accepted, so grants go 1,0,1,0...
    for (int j = 0; j < 20; j++) begin
      req_valid = {4'b0000, req_ready[1:0]};
      req_tag[3:0] = 4'(j);
      req_tag[7:4] = 4'(j);
      tick();
      if (j >= 1) begin
        nvec++; if (cdb_valid !== 1'b1 || cdb_src !== ((j % 2 == 1) ? 3'd1 : 3'd0)) begin nerr++; $display("FAIL fair_cycle%0d: got v=%b src=%0d expected v=1 src=%0d", j, cdb_valid, cdb_src, (j % 2 == 1) ? 1 : 0); end
      end
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL fair_no_overflow: got %b expected 0", err_overflow); end
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL fair_drain: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) set_req(i, 4'(i + 1), 32'hB000_0000 + i);
    tick();
    req_valid = '0;
    set_req(5, 4'hE, 32'h5555_5555);
    tick();
    req_valid = '0;
    nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd0) begin nerr++; $display("FAIL ovf_first: got v=%b src=%0d expected v=1 src=0", cdb_valid, cdb_src); end
    nvec++; if (err_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b expected 1", err_overflow); end
    for (int i = 1; i < 6; i++) begin
      tick();
      nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'(i) || cdb_tag !== 4'(i + 1) || cdb_data !== 32'hB000_0000 + i) begin nerr++; $display("FAIL ovf_seq%0d: got v=%b src=%0d tag=%h data=%h expected v=1 src=%0d tag=%h data=%h", i, cdb_valid, cdb_src, cdb_tag, cdb_data, i, 4'(i + 1), 32'hB000_0000 + i); end
    end
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL ovf_dropped_broadcast: got %b expected 0", cdb_valid); end
    nvec++; if (err_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b expected 1", err_overflow); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 6; i++) set_req(i, 4'(i + 1), 32'hC000_0000 + i);
    tick();
    req_valid = '0;
    tick();
    nvec++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'h1) begin nerr++; $display("FAIL rstmid_pre: got v=%b tag=%h expected v=1 tag=1", cdb_valid, cdb_tag); end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'h0 || cdb_data !== 32'h0 || cdb_src !== 3'd0) begin nerr++; $display("FAIL rstmid_bus: got v=%b tag=%h data=%h src=%0d expected all 0", cdb_valid, cdb_tag, cdb_data, cdb_src); end
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL rstmid_err: got %b expected 0", err_overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++; if (req_ready !== 6'b111111) begin nerr++; $display("FAIL rstmid_ready: got %b expected 111111", req_ready); end
    tick();
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_empty: got %b expected 0", cdb_valid); end
  endtask

  task automatic test_flush();
    set_req(0, 4'hC, 32'hF000_0000);
    set_req(1, 4'hD, 32'hF000_0001);
    set_req(2, 4'hE, 32'hF000_0002);
    tick();
    req_valid = '0;
    flush = 1'b1;
    set_req(2, 4'h7, 32'h7777_7777);
    tick();
    flush = 1'b0;
    req_valid = '0;
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid: got %b expected 0", cdb_valid); end
    nvec++; if (req_ready !== 6'b111111) begin nerr++; $display("FAIL flush_empty: got %b expected 111111", req_ready); end
    nvec++; if (err_overflow !== 1'b0) begin nerr++; $display("FAIL flush_no_overflow: got %b expected 0", err_overflow); end
    for (int k = 0; k < 2; k++) begin
      tick();
      nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL flush_quiet%0d: got %b expected 0", k, cdb_valid); end
    end
    set_req(4, 4'h9, 32'h1234_5678);
    tick();
    req_valid = '0;
    tick();
    nvec++; if (cdb_valid !== 1'b1 || cdb_src !== 3'd4 || cdb_tag !== 4'h9 || cdb_data !== 32'h1234_5678) begin nerr++; $display("FAIL flush_after: got v=%b src=%0d tag=%h data=%h expected v=1 src=4 tag=9 data=12345678", cdb_valid, cdb_src, cdb_tag, cdb_data); end
    tick();
    nvec++; if (cdb_valid !== 1'b0) begin nerr++; $display("FAIL flush_after_once: got %b expected 0", cdb_valid); end
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_all_six();
    test_wrap_fair();
    test_overflow();
    test_reset_midrun();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
